// File: rtl/kp_window_ctrl_if.sv
// Pixel-in / window-out bundle between a raster source, kp_window_ctrl and a 3x3 kernel.
// No storage; it only groups the handshake and window signals.
// The source sees o_ready, and the kernel sees o_valid plus three 3-pixel rows.
interface kp_window_ctrl_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0]   i_data;
   logic                    i_valid;
   logic                    o_ready;
   logic [3*DATA_WIDTH-1:0] o_r0_data;
   logic [3*DATA_WIDTH-1:0] o_r1_data;
   logic [3*DATA_WIDTH-1:0] o_r2_data;
   logic                    o_valid;

   // Pixel source and window consumer side.
   modport master (
      output i_data, i_valid,
      input  o_ready, o_r0_data, o_r1_data, o_r2_data, o_valid
   );

   // Line-buffer controller side.
   modport slave (
      input  i_data, i_valid,
      output o_ready, o_r0_data, o_r1_data, o_r2_data, o_valid
   );
endinterface

// File: rtl/kp_window_ctrl.sv
// Four rotating line buffers that replay three stored lines as 3x3 windows for the kernel.
// Latency: the column-c window is registered 2 cycles after its RAM read, with no border windows.
// Backpressure: o_ready drops only while all 4 buffers hold unread lines; the kernel side never stalls.
// Optional status ports (o_lines_buffered, o_overrun) are present when KP_WINDOW_CTRL_STATUS_EN is defined.
module kp_window_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int LINE_WIDTH = 640,
   parameter int PTR_WIDTH  = 10
) (
   input  logic                i_clk,
   input  logic                i_rstn,
   kp_window_ctrl_if.slave     bus
`ifdef KP_WINDOW_CTRL_STATUS_EN
   ,
   output logic [2:0]          o_lines_buffered,
   output logic [0:0]          o_overrun
`endif
);

   localparam logic [PTR_WIDTH-1:0] LAST_COL = PTR_WIDTH'(LINE_WIDTH - 1);
   localparam logic [PTR_WIDTH-1:0] FIRST_WIN_COL = PTR_WIDTH'(2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [PTR_WIDTH-1:0]    wptr_q, wptr_d;
   logic [1:0]              wsel_q, wsel_d;
   logic [PTR_WIDTH-1:0]    rptr_q, rptr_d;
   logic [1:0]              rsel_q, rsel_d;
   logic [2:0]              lines_q, lines_d;

   logic [DATA_WIDTH-1:0]   lbuf_q [4][LINE_WIDTH];
   logic [DATA_WIDTH-1:0]   rd0_q, rd1_q, rd2_q;
   logic                    rdv_q;
   logic [PTR_WIDTH-1:0]    rcol_q;

   logic [3*DATA_WIDTH-1:0] win0_q, win1_q, win2_q;
   logic                    win_vld_q;

   logic                    xfer;
   logic                    wr_line_done;
   logic                    rd_line_done;
   logic                    rd_en;
   logic                    clr_win;
   logic [1:0]              rsel1, rsel2;

   assign rsel1 = rsel_q + 2'd1;
   assign rsel2 = rsel_q + 2'd2;

   // A fourth unread line means the next write would land on a row still to be replayed.
   assign bus.o_ready  = (lines_q < 3'd4);
   assign xfer         = bus.i_valid & bus.o_ready;
   assign wr_line_done = xfer && (wptr_q == LAST_COL);

   // Write pointer walks the current line, then rotates to the next buffer.
   always_comb begin
      wptr_d = wptr_q;
      wsel_d = wsel_q;
      if (xfer) begin
         if (wr_line_done) begin
            wptr_d = '0;
            wsel_d = wsel_q + 2'd1;
         end else begin
            wptr_d = wptr_q + PTR_WIDTH'(1);
         end
      end
   end

   // Read sequencer: wait for 3 lines, stream one full line without stalls, flush the RAM latency.
   always_comb begin
      state_d      = state_q;
      rptr_d       = rptr_q;
      rsel_d       = rsel_q;
      rd_en        = 1'b0;
      clr_win      = 1'b0;
      rd_line_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (lines_q >= 3'd3) begin
               state_d = READ;
               rptr_d  = '0;
               clr_win = 1'b1;
            end
         end
         READ: begin
            rd_en = 1'b1;
            if (rptr_q == LAST_COL) begin
               state_d = DRAIN;
            end else begin
               rptr_d = rptr_q + PTR_WIDTH'(1);
            end
         end
         DRAIN: begin
            rd_line_done = 1'b1;
            rsel_d       = rsel_q + 2'd1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Occupancy: a completed write and a finished replay in the same cycle cancel out.
   always_comb begin
      lines_d = lines_q;
      case ({wr_line_done, rd_line_done})
         2'b10:   lines_d = lines_q + 3'd1;
         2'b01:   lines_d = lines_q - 3'd1;
         default: lines_d = lines_q;
      endcase
   end

   // Control state registers.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= IDLE;
         wptr_q  <= '0;
         wsel_q  <= '0;
         rptr_q  <= '0;
         rsel_q  <= '0;
         lines_q <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         wsel_q  <= wsel_d;
         rptr_q  <= rptr_d;
         rsel_q  <= rsel_d;
         lines_q <= lines_d;
      end
   end

   // Line buffer RAM: one write port, three synchronous read ports sharing the column address.
   always_ff @(posedge i_clk) begin
      if (xfer) begin
         lbuf_q[wsel_q][wptr_q] <= bus.i_data;
      end
      if (rd_en) begin
         rd0_q <= lbuf_q[rsel_q][rptr_q];
         rd1_q <= lbuf_q[rsel1][rptr_q];
         rd2_q <= lbuf_q[rsel2][rptr_q];
      end
   end

   // Tag returning read data with its column so windows can be qualified.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         rdv_q  <= 1'b0;
         rcol_q <= '0;
      end else begin
         rdv_q  <= rd_en;
         rcol_q <= rd_en ? rptr_q : rcol_q;
      end
   end

   // Window shift registers: newest column enters the low field, columns 0 and 1 only prime the rows.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         win0_q    <= '0;
         win1_q    <= '0;
         win2_q    <= '0;
         win_vld_q <= 1'b0;
      end else if (clr_win) begin
         win0_q    <= '0;
         win1_q    <= '0;
         win2_q    <= '0;
         win_vld_q <= 1'b0;
      end else if (rdv_q) begin
         win0_q    <= {win0_q[2*DATA_WIDTH-1:0], rd0_q};
         win1_q    <= {win1_q[2*DATA_WIDTH-1:0], rd1_q};
         win2_q    <= {win2_q[2*DATA_WIDTH-1:0], rd2_q};
         win_vld_q <= (rcol_q >= FIRST_WIN_COL);
      end else begin
         win_vld_q <= 1'b0;
      end
   end

   assign bus.o_r0_data = win0_q;
   assign bus.o_r1_data = win1_q;
   assign bus.o_r2_data = win2_q;
   assign bus.o_valid   = win_vld_q;

   // A write into a row being replayed would corrupt the windows in flight.
   always @(posedge i_clk) begin
      if (i_rstn && xfer && (state_q != IDLE)) begin
         assert ((wsel_q != rsel_q) && (wsel_q != rsel1) && (wsel_q != rsel2));
      end
   end

`ifdef KP_WINDOW_CTRL_STATUS_EN
   logic overrun_q;

   // Sticky record of a pixel offered while the buffers were full.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         overrun_q <= 1'b0;
      end else if (bus.i_valid && !bus.o_ready) begin
         overrun_q <= 1'b1;
      end
   end

   assign o_lines_buffered = lines_q;
   assign o_overrun        = overrun_q;
`endif

endmodule

// File: tb/tb_kp_window_ctrl.sv
// Directed bench for kp_window_ctrl with 8-bit pixels and 8-pixel lines.
// Pixel value is 16*line + column; each row packs column c in the low byte and c-2 in the high byte.
// Occupancy is rebuilt from completed written lines minus replayed lines (6 windows each).
module tb_kp_window_ctrl;
   localparam int DW = 8;
   localparam int LW = 8;
   localparam int WPL = LW - 2;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   kp_window_ctrl_if #(.DATA_WIDTH(DW)) bus ();

`ifdef KP_WINDOW_CTRL_STATUS_EN
   logic [2:0] lb_o;
   logic [0:0] ovr_o;
`endif

   kp_window_ctrl #(
      .DATA_WIDTH(DW),
      .LINE_WIDTH(LW),
      .PTR_WIDTH (3)
   ) dut (
      .i_clk (clk),
      .i_rstn(rstn),
      .bus   (bus)
`ifdef KP_WINDOW_CTRL_STATUS_EN
      ,
      .o_lines_buffered(lb_o),
      .o_overrun       (ovr_o)
`endif
   );

   int checks = 0;
   int errors = 0;

   int xfer = 0;
   int lines_w = 0;
   int cyc = 0;
   int win_cnt = 0;
   int first_xfer = -1;
   int inv_err = 0;
   int stat_err = 0;
   int saw_full = 0;
   int lb_m;
   logic [71:0] win_a [64];
   int          win_cyc [64];

   function automatic logic [7:0] pix(input int l, input int c);
      return 8'((16 * l + c) & 255);
   endfunction

   function automatic logic [23:0] row(input int l, input int c);
      return {pix(l, c - 2), pix(l, c - 1), pix(l, c)};
   endfunction

   function automatic logic [71:0] exp_win(input int i);
      int b;
      int c;
      b = i / WPL;
      c = 2 + (i % WPL);
      return {row(b, c), row(b + 1, c), row(b + 2, c)};
   endfunction

   task automatic check_vec(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_int({tag, "_valid"}, int'(bus.o_valid), 0);
      check_int({tag, "_ready"}, int'(bus.o_ready), 1);
      check_vec({tag, "_rows"}, {bus.o_r0_data, bus.o_r1_data, bus.o_r2_data}, 72'h0);
   endtask

   task automatic send_pixel(input logic [7:0] v);
      int guard;
      guard = 0;
      @(negedge clk);
      bus.i_data  = v;
      bus.i_valid = 1'b1;
      while (!bus.o_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) begin
         checks++;
         errors++;
         $error("FAIL stall_timeout: observed o_ready=0 for %0d cycles, expected release", guard);
      end
   endtask

   task automatic send_line(input int l);
      for (int c = 0; c < LW; c++) send_pixel(pix(l, c));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.i_valid = 1'b0;
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      bus.i_valid = 1'b0;
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   // Count accepted pixels and completed lines at the active edge.
   always @(posedge clk) begin
      if (!rstn) begin
         xfer    = 0;
         lines_w = 0;
      end else if (bus.i_valid && bus.o_ready) begin
         xfer++;
         if (xfer % LW == 0) lines_w++;
      end
   end

   // Capture windows and check o_ready against the reconstructed occupancy.
   always @(negedge clk) begin
      cyc++;
      if (!rstn) begin
         win_cnt    = 0;
         first_xfer = -1;
         saw_full   = 0;
      end else begin
         if (bus.o_valid) begin
            if (win_cnt < 64) begin
               win_a[win_cnt]   = {bus.o_r0_data, bus.o_r1_data, bus.o_r2_data};
               win_cyc[win_cnt] = cyc;
            end
            if (win_cnt == 0) first_xfer = xfer;
            win_cnt++;
         end
         lb_m = lines_w - win_cnt / WPL;
         if (bus.o_ready !== (lb_m < 4)) inv_err++;
         if (lb_m == 4) saw_full = 1;
`ifdef KP_WINDOW_CTRL_STATUS_EN
         if (int'(lb_o) != lb_m) stat_err++;
`endif
      end
   end

   initial begin
      bus.i_data  = '0;
      bus.i_valid = 1'b0;
      rstn        = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
`ifdef KP_WINDOW_CTRL_STATUS_EN
      check_int("por_overrun", int'(ovr_o), 0);
`endif
      rstn = 1'b1;

      // Partial stream, then reset mid-line.
      for (int p = 0; p < 12; p++) send_pixel(pix(p / LW, p % LW));
      @(negedge clk);
      bus.i_valid = 1'b0;
      #2 rstn = 1'b0;
      #1 check_reset_outputs("midline_rst");
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      // Three lines, then line 3 timed to finish on the edge the first replay ends.
      send_line(0);
      send_line(1);
      send_line(2);
      idle(2);
      send_line(3);
      idle(30);
      check_int("fill_windows", win_cnt, 12);
      check_int("fill_no_early_valid", int'(first_xfer >= 24), 1);
      check_vec("fill_first_r0", 72'(win_a[0][71:48]), 72'h000102);
      check_vec("fill_first_r1", 72'(win_a[0][47:24]), 72'h101112);
      check_vec("fill_first_r2", 72'(win_a[0][23:0]), 72'h202122);
      check_int("fill_back_to_back", win_cyc[WPL - 1] - win_cyc[0], WPL - 1);
      check_int("simul_next_read_gap", win_cyc[WPL] - win_cyc[0], 10);
      for (int i = 0; i < 12; i++) check_vec($sformatf("fill_win%0d", i), win_a[i], exp_win(i));
      check_int("fill_ready_vs_occupancy", inv_err, 0);

      // Ten continuous lines with i_valid held high through stalls.
      pulse_reset();
      for (int l = 0; l < 10; l++) send_line(l);
      idle(60);
      check_int("cont_windows", win_cnt, 48);
      check_int("cont_no_early_valid", int'(first_xfer >= 24), 1);
      check_int("cont_buffers_filled", saw_full, 1);
      for (int i = 0; i < 48; i++) check_vec($sformatf("cont_win%0d", i), win_a[i], exp_win(i));
      check_int("cont_ready_vs_occupancy", inv_err, 0);
`ifdef KP_WINDOW_CTRL_STATUS_EN
      check_int("status_overrun_set", int'(ovr_o), 1);
      idle(5);
      check_int("status_overrun_sticky", int'(ovr_o), 1);
      check_int("status_lines_buffered", stat_err, 0);
`endif

      // Reset while windows are streaming, then restart from fresh lines.
      pulse_reset();
`ifdef KP_WINDOW_CTRL_STATUS_EN
      check_int("status_overrun_cleared", int'(ovr_o), 0);
`endif
      send_line(0);
      send_line(1);
      send_line(2);
      idle(8);
      check_int("midread_streaming", int'(win_cnt > 0 && bus.o_valid), 1);
      #2 rstn = 1'b0;
      #1 check_reset_outputs("midread_rst");
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      send_line(0);
      send_line(1);
      idle(20);
      check_int("restart_two_lines_quiet", win_cnt, 0);
      send_line(2);
      idle(20);
      check_int("restart_windows", win_cnt, WPL);
      check_int("restart_no_early_valid", int'(first_xfer >= 24), 1);
      check_vec("restart_first_win", win_a[0], exp_win(0));
      check_int("final_ready_vs_occupancy", inv_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
